// File: rtl/opc_memsys.sv
// Memory and I/O subsystem for OPC-family CPUs: wait-stated program/data and I/O
// spaces stretched through clken, plus LFSR-driven active-low interrupt channels.
module opc_memsys #(
    parameter int          AW           = 20,
    parameter int          DW           = 32,
    parameter int          MEM_DEPTH    = 1 << 20,
    parameter int          IO_DEPTH     = 1 << 16,
    parameter int          MEM_WAIT     = 0,
    parameter int          IO_WAIT      = 2,
    parameter int          NINT         = 2,
    parameter logic [7:0]  INT_THRESH   = 8'd218,
    parameter int          INT_PRESCALE = 5,
    parameter int          INT_PULSE    = 1,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic [AW-1:0]   address,
    input  logic [DW-1:0]   dout,
    output logic [DW-1:0]   din,
    input  logic            rnw,
    input  logic            vpa,
    input  logic            vda,
    input  logic            vio,
    output logic            clken,
    input  logic [NINT-1:0] int_en,
    output logic [NINT-1:0] int_b,
    output logic            wr_stb,
    output logic            wr_io
);

    localparam int MIW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int IIW = (IO_DEPTH > 1) ? $clog2(IO_DEPTH) : 1;
    localparam int LW  = (MIW > IIW) ? MIW : IIW;
    localparam int PW  = $clog2(INT_PULSE + 1);
    localparam int PSW = (INT_PRESCALE > 1) ? $clog2(INT_PRESCALE) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic            lat_io;
    logic            lat_rnw;
    logic [LW-1:0]   lat_addr;
    logic [DW-1:0]   lat_data;

    logic [DW-1:0]   mem    [MEM_DEPTH];
    logic [DW-1:0]   io_mem [IO_DEPTH];

    logic            req;
    logic [3:0]      req_wait;
    logic            acc_done;
    logic            acc_io;
    logic            acc_rnw;
    logic [LW-1:0]   acc_addr;
    logic [DW-1:0]   acc_data;
    logic            mem_we;
    logic            io_we;
    logic            addr_unused;

    // Upper address bits beyond the larger space are intentionally ignored.
    assign addr_unused = ^address;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        req      = clken & (vpa | vda | vio);
        req_wait = vio ? 4'(IO_WAIT) : 4'(MEM_WAIT);
        acc_io   = lat_io;
        acc_rnw  = lat_rnw;
        acc_addr = lat_addr;
        acc_data = lat_data;
        acc_done = 1'b0;
        if (state == S_IDLE) begin
            // Zero-wait accesses complete straight from the live bus.
            acc_io   = vio;
            acc_rnw  = rnw;
            acc_addr = address[LW-1:0];
            acc_data = dout;
            acc_done = req && (req_wait == 4'd0);
        end else begin
            acc_done = (cnt == 4'd1);
        end
        mem_we = reset_b && acc_done && !acc_rnw && !acc_io;
        io_we  = reset_b && acc_done && !acc_rnw &&  acc_io;
    end

    // NOTE: storage arrays carry no reset; their contents are undefined until written.
    always_ff @(posedge clk) begin
        if (mem_we) mem[acc_addr[MIW-1:0]]   <= acc_data;
        if (io_we)  io_mem[acc_addr[IIW-1:0]] <= acc_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            clken    <= 1'b1;
            din      <= '0;
            wr_stb   <= 1'b0;
            wr_io    <= 1'b0;
            lat_io   <= 1'b0;
            lat_rnw  <= 1'b1;
            lat_addr <= '0;
            lat_data <= '0;
        end else begin
            wr_stb <= acc_done && !acc_rnw;
            if (acc_done) begin
                if (acc_rnw) din   <= acc_io ? io_mem[acc_addr[IIW-1:0]] : mem[acc_addr[MIW-1:0]];
                else         wr_io <= acc_io;
            end
            case (state)
                S_IDLE: begin
                    if (req && (req_wait != 4'd0)) begin
                        lat_io   <= vio;
                        lat_rnw  <= rnw;
                        lat_addr <= address[LW-1:0];
                        lat_data <= dout;
                        cnt      <= req_wait;
                        clken    <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt   <= 4'd0;
                        clken <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [15:0]     lfsr;
    logic [15:0]     lfsr_next;
    logic [PSW-1:0]  presc;
    logic            tick;
    logic [NINT-1:0] chan_hit;
    logic [PW-1:0]   pcnt [NINT];
    logic [7:0]      chan_src;
    logic [15:0]     rot_buf;

    // Channels judge the freshly advanced LFSR value; odd channels use the high byte.
    always_comb begin
        lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        tick      = (presc == PSW'(INT_PRESCALE - 1));
        chan_hit  = '0;
        chan_src  = 8'd0;
        rot_buf   = 16'd0;
        for (int i = 0; i < NINT; i++) begin
            chan_src    = (i % 2 == 1) ? lfsr_next[15:8] : lfsr_next[7:0];
            rot_buf     = {chan_src, chan_src} << (i / 2);
            chan_hit[i] = (rot_buf[15:8] > INT_THRESH);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            lfsr  <= SEED;
            presc <= '0;
            int_b <= '1;
            for (int i = 0; i < NINT; i++) pcnt[i] <= '0;
        end else begin
            if (tick) begin
                presc <= '0;
                lfsr  <= lfsr_next;
            end else begin
                presc <= presc + PSW'(1);
            end
            // A low pulse always runs to length; int_en only gates new events.
            for (int i = 0; i < NINT; i++) begin
                if (!int_b[i]) begin
                    if (pcnt[i] == PW'(1)) int_b[i] <= 1'b1;
                    else                   pcnt[i]  <= pcnt[i] - PW'(1);
                end else if (tick && int_en[i] && chan_hit[i]) begin
                    int_b[i] <= 1'b0;
                    pcnt[i]  <= PW'(INT_PULSE);
                end
            end
        end
    end

endmodule

// File: tb/tb_opc_memsys.sv
// Self-checking bench for opc_memsys: two instances (zero/IO-wait and 3-wait memory)
// share one bus; a model memory feeds a read-data scoreboard queue.
module tb_opc_memsys;

    localparam int AW       = 20;
    localparam int DW       = 32;
    localparam int DEPTH    = 1024;
    localparam int IO_A     = 1 << 16;
    localparam int IO_B     = 256;
    localparam int PRESC    = 5;
    localparam int PULSE    = 3;
    localparam int NCYC     = 10000;

    logic          clk = 1'b0;
    logic          reset_b;
    logic [AW-1:0] address;
    logic [DW-1:0] dout;
    logic          rnw, vpa, vda, vio;
    logic          sel;
    logic [1:0]    int_en_a, int_en_b;

    logic [DW-1:0] din_a, din_b;
    logic          clken_a, clken_b, wr_stb_a, wr_stb_b, wr_io_a, wr_io_b;
    logic [1:0]    int_b_a, int_b_b;

    logic [DW-1:0] din_s;
    logic          clken_s, wr_stb_s, wr_io_s;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model [int];

    always #5 clk = ~clk;

    opc_memsys #(
        .AW(AW), .DW(DW), .MEM_DEPTH(DEPTH), .IO_DEPTH(IO_A), .MEM_WAIT(0), .IO_WAIT(2),
        .NINT(2), .INT_THRESH(8'd218), .INT_PRESCALE(PRESC), .INT_PULSE(PULSE), .SEED(16'hACE1)
    ) u_dut_a (
        .clk(clk), .reset_b(reset_b), .address(address), .dout(dout), .din(din_a),
        .rnw(rnw), .vpa(vpa & ~sel), .vda(vda & ~sel), .vio(vio & ~sel), .clken(clken_a),
        .int_en(int_en_a), .int_b(int_b_a), .wr_stb(wr_stb_a), .wr_io(wr_io_a)
    );

    opc_memsys #(
        .AW(AW), .DW(DW), .MEM_DEPTH(DEPTH), .IO_DEPTH(IO_B), .MEM_WAIT(3), .IO_WAIT(2),
        .NINT(2), .INT_THRESH(8'd218), .INT_PRESCALE(PRESC), .INT_PULSE(1), .SEED(16'hACE1)
    ) u_dut_b (
        .clk(clk), .reset_b(reset_b), .address(address), .dout(dout), .din(din_b),
        .rnw(rnw), .vpa(vpa & sel), .vda(vda & sel), .vio(vio & sel), .clken(clken_b),
        .int_en(int_en_b), .int_b(int_b_b), .wr_stb(wr_stb_b), .wr_io(wr_io_b)
    );

    assign din_s    = sel ? din_b    : din_a;
    assign clken_s  = sel ? clken_b  : clken_a;
    assign wr_stb_s = sel ? wr_stb_b : wr_stb_a;
    assign wr_io_s  = sel ? wr_io_b  : wr_io_a;

    function automatic int mkey(input bit io, input logic [AW-1:0] addr);
        int a;
        int idx;
        a   = int'(addr);
        idx = io ? (a % (sel ? IO_B : IO_A)) : (a % DEPTH);
        return (int'(sel) << 30) | (int'(io) << 29) | idx;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset_b = 1'b0;
        vpa = 1'b0; vda = 1'b0; vio = 1'b0; rnw = 1'b1;
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
    endtask

    // Drives one access at a clken-high negedge and returns at the first clken-high
    // negedge after it, so consecutive calls issue back-to-back requests.
    task automatic bus_access(input bit io, input bit both, input logic [AW-1:0] addr,
                              input bit rd, input logic [31:0] wdata, input int exp_wait,
                              input string name);
        int          stall;
        int          key;
        logic [31:0] exp_d;
        key     = mkey(io, addr);
        address = addr;
        dout    = wdata;
        rnw     = rd;
        vio     = io;
        vpa     = rd && !io;
        vda     = (!rd && !io) || both;
        if (rd) exp_q.push_back(model[key]);
        else    model[key] = wdata;
        @(negedge clk);
        vpa = 1'b0; vda = 1'b0; vio = 1'b0; rnw = 1'b1;
        stall = 0;
        while (clken_s !== 1'b1 && stall < 40) begin
            stall++;
            @(negedge clk);
        end
        tests_run++;
        if (stall != exp_wait) begin
            tests_failed++;
            $display("FAIL %s stall: got %0d clken-low cycles, expected %0d", name, stall, exp_wait);
        end
        if (rd) begin
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            tests_run++;
            if (din_s !== exp_d) begin
                tests_failed++;
                $display("FAIL %s din: got %h, expected %h", name, din_s, exp_d);
            end
        end else begin
            tests_run++;
            if (wr_stb_s !== 1'b1 || wr_io_s !== io) begin
                tests_failed++;
                $display("FAIL %s strobe: got wr_stb=%b wr_io=%b, expected 1 %b", name, wr_stb_s, wr_io_s, io);
            end
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        apply_reset();
        tests_run++;
        if ({clken_a, wr_stb_a, wr_io_a, int_b_a} !== 5'b1_0_0_11) begin
            tests_failed++;
            $display("FAIL reset_a ctrl: got %b, expected 10011", {clken_a, wr_stb_a, wr_io_a, int_b_a});
        end
        tests_run++;
        if ({clken_b, wr_stb_b, wr_io_b, int_b_b} !== 5'b1_0_0_11) begin
            tests_failed++;
            $display("FAIL reset_b ctrl: got %b, expected 10011", {clken_b, wr_stb_b, wr_io_b, int_b_b});
        end
        tests_run++;
        if (din_a !== 32'd0 || din_b !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset din: got %h %h, expected 0 0", din_a, din_b);
        end
    endtask

    task automatic test_zero_wait();
        sel = 1'b0;
        bus_access(1'b0, 1'b0, 20'h00010, 1'b0, 32'hDEADBEEF, 0, "zw_write");
        @(negedge clk);
        tests_run++;
        if (wr_stb_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL zw_strobe_width: got wr_stb=%b one cycle later, expected 0", wr_stb_a);
        end
        bus_access(1'b0, 1'b0, 20'h00010, 1'b1, 32'h0, 0, "zw_read");
        @(negedge clk);
        tests_run++;
        if (din_a !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL zw_hold: got %h while idle, expected deadbeef", din_a);
        end
    endtask

    task automatic test_io_wait();
        sel = 1'b0;
        bus_access(1'b1, 1'b0, 20'h0FE08, 1'b0, 32'h41, 2, "io_write");
        bus_access(1'b1, 1'b0, 20'h0FE08, 1'b1, 32'h0, 2, "io_read");
    endtask

    task automatic test_alias();
        sel = 1'b0;
        bus_access(1'b0, 1'b0, 20'h00400, 1'b0, 32'h12345678, 0, "alias_write");
        bus_access(1'b0, 1'b0, 20'h00000, 1'b1, 32'h0, 0, "alias_mem_read");
        bus_access(1'b1, 1'b0, 20'h1FE08, 1'b1, 32'h0, 2, "alias_io_read");
    endtask

    task automatic test_precedence();
        sel = 1'b0;
        bus_access(1'b0, 1'b0, 20'h00008, 1'b0, 32'hCAFEF00D, 0, "prec_mem_write");
        bus_access(1'b1, 1'b1, 20'h00008, 1'b0, 32'h55AA55AA, 2, "prec_both_write");
        bus_access(1'b0, 1'b0, 20'h00008, 1'b1, 32'h0, 0, "prec_mem_read");
        bus_access(1'b1, 1'b0, 20'h00008, 1'b1, 32'h0, 2, "prec_io_read");
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [8];
        bit            spaces[8];
        int            j;
        sel = 1'b0;
        for (int i = 0; i < 8; i++) begin
            spaces[i] = bit'($urandom_range(0, 1));
            addrs[i]  = AW'($urandom_range(0, (1 << AW) - 1));
            bus_access(spaces[i], 1'b0, addrs[i], 1'b0, $urandom, spaces[i] ? 2 : 0, "b2b_write");
            j = $urandom_range(0, i);
            bus_access(spaces[j], 1'b0, addrs[j], 1'b1, 32'h0, spaces[j] ? 2 : 0, "b2b_read");
        end
    endtask

    task automatic test_reset_mid_wait();
        sel = 1'b1;
        bus_access(1'b0, 1'b0, 20'h00020, 1'b0, 32'h11111111, 3, "rmw_init");
        address = 20'h00020; dout = 32'hBADBAD00; rnw = 1'b0; vda = 1'b1;
        @(negedge clk);
        vda = 1'b0; rnw = 1'b1;
        tests_run++;
        if (clken_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmw_stall: got clken=%b, expected 0", clken_b);
        end
        @(negedge clk);
        reset_b = 1'b0;
        @(negedge clk);
        tests_run++;
        if (clken_b !== 1'b1 || wr_stb_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmw_abort: got clken=%b wr_stb=%b, expected 1 0", clken_b, wr_stb_b);
        end
        reset_b = 1'b1;
        @(negedge clk);
        tests_run++;
        if (wr_stb_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmw_late_stb: got wr_stb=%b, expected 0", wr_stb_b);
        end
        bus_access(1'b0, 1'b0, 20'h00020, 1'b1, 32'h0, 3, "rmw_readback");
    endtask

    task automatic test_interrupts();
        logic [15:0] m_lfsr;
        int          m_presc, m_low, fb;
        int          ev_q [$];
        int          n_model, n_seen, ch1_low, early, low_len, exp_cyc;
        logic        prev;
        logic [1:0]  obs;
        bit          tick;
        sel = 1'b0;
        apply_reset();
        m_lfsr = 16'hACE1; m_presc = 0; m_low = 0;
        n_model = 0; n_seen = 0; ch1_low = 0; early = 0; low_len = 0; prev = 1'b1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            obs = int_b_a;
            if (obs[1] !== 1'b1) ch1_low++;
            if (obs[0] === 1'b0) low_len++;
            if (obs[0] === 1'b0 && prev === 1'b1) begin
                n_seen++;
                if (cyc < PRESC) early++;
                exp_cyc = (ev_q.size() > 0) ? ev_q.pop_front() : -1;
                tests_run++;
                if (exp_cyc != cyc) begin
                    tests_failed++;
                    $display("FAIL int_event_time: got fall at cycle %0d, expected %0d", cyc, exp_cyc);
                end
            end
            if (obs[0] === 1'b1 && prev === 1'b0) begin
                tests_run++;
                if (low_len != PULSE) begin
                    tests_failed++;
                    $display("FAIL int_pulse_width: got %0d cycles low, expected %0d", low_len, PULSE);
                end
                low_len = 0;
            end
            prev = obs[0];
            // Reference model for the edge closing this cycle.
            tick = (m_presc == PRESC - 1);
            if (tick) begin
                fb      = (m_lfsr >> 0 ^ m_lfsr >> 2 ^ m_lfsr >> 3 ^ m_lfsr >> 5) & 1;
                m_lfsr  = (m_lfsr >> 1) | 16'(fb << 15);
                m_presc = 0;
            end else begin
                m_presc++;
            end
            if (m_low > 0) begin
                m_low--;
            end else if (tick && (m_lfsr & 16'h00FF) > 16'd218) begin
                m_low = PULSE;
                if (cyc + 1 < NCYC) begin
                    ev_q.push_back(cyc + 1);
                    n_model++;
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (n_seen != n_model || ev_q.size() != 0) begin
            tests_failed++;
            $display("FAIL int_event_count: got %0d events, expected %0d", n_seen, n_model);
        end
        tests_run++;
        if (ch1_low != 0) begin
            tests_failed++;
            $display("FAIL int_ch1_quiet: got %0d low cycles, expected 0", ch1_low);
        end
        tests_run++;
        if (early != 0) begin
            tests_failed++;
            $display("FAIL int_first_event: got %0d events before cycle %0d, expected 0", early, PRESC);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset_b  = 1'b0;
        sel      = 1'b0;
        address  = '0;
        dout     = '0;
        rnw      = 1'b1;
        vpa      = 1'b0;
        vda      = 1'b0;
        vio      = 1'b0;
        int_en_a = 2'b01;
        int_en_b = 2'b00;
        test_reset();
        test_zero_wait();
        test_io_wait();
        test_alias();
        test_precedence();
        test_back_to_back();
        test_reset_mid_wait();
        test_interrupts();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
